// File: rtl/dcm_lock_seq.sv
// Reset and lock sequencer for two cascaded DCMs (DCM2 fed from DCM1 CLKFX).
// Runs on the free-running bus clock; SYS_RST is held until both locks have settled.
module dcm_lock_seq #(
    parameter int unsigned RST_CYCLES    = 3,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRY     = 4
) (
    input  logic       BUS_CLK,
    input  logic       BUS_RST,
    input  logic       USER_RST,
    input  logic       LOCKED1,
    input  logic       LOCKED2,
    input  logic       STATUS1_CLKIN_STOP,
    input  logic       STATUS2_CLKIN_STOP,
    output logic       DCM1_RST,
    output logic       DCM2_RST,
    output logic       SYS_RST,
    output logic       READY,
    output logic       ERROR,
    output logic [7:0] RELOCK_CNT
);
    localparam int unsigned CNT_MAX_A = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > RST_CYCLES) ? CNT_MAX_A : RST_CYCLES;
    localparam int unsigned CW        = $clog2(CNT_MAX + 1);
    localparam int unsigned RW        = $clog2(MAX_RETRY + 1);

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_RESET1,
        S_WAIT1,
        S_RESET2,
        S_WAIT2,
        S_SETTLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [7:0]    relock_q, relock_d, relock_inc;
    logic [3:0]    meta_q, sync_q;
    logic          l1, l2, s1, s2;
    logic          timeout;
    logic          dcm1_rst_q, dcm2_rst_q, sys_rst_q, ready_q, error_q;
    logic          dcm1_rst_d, dcm2_rst_d, sys_rst_d, ready_d, error_d;

    assign l1 = sync_q[0];
    assign l2 = sync_q[1];
    assign s1 = sync_q[2];
    assign s2 = sync_q[3];

    assign relock_inc = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        retry_d  = retry_q;
        relock_d = relock_q;
        timeout  = 1'b0;
        case (state_q)
            S_RESET1: if (cnt_q == RST_LAST) state_d = S_WAIT1;
            S_WAIT1: begin
                if (l1 && !s1)              state_d = S_RESET2;
                else if (cnt_q == TO_LAST)  timeout = 1'b1;
            end
            S_RESET2: begin
                if (!l1)                    state_d = S_RESET1;
                else if (cnt_q == RST_LAST) state_d = S_WAIT2;
            end
            S_WAIT2: begin
                if (!l1)                    state_d = S_RESET1;
                else if (l2)                state_d = S_SETTLE;
                else if (cnt_q == TO_LAST)  timeout = 1'b1;
            end
            S_SETTLE: begin
                if (!l1 || s1)              state_d = S_RESET1;
                else if (!l2 || s2)         state_d = S_RESET2;
                else if (cnt_q == SETTLE_LAST) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                if (!l1 || s1) begin
                    state_d  = S_RESET1;
                    relock_d = relock_inc;
                end else if (!l2 || s2) begin
                    state_d  = S_RESET2;
                    relock_d = relock_inc;
                end
            end
            S_FAIL:  state_d = S_FAIL;
            default: state_d = S_RESET1;
        endcase

        // A timeout in either wait state restarts the whole cascade.
        if (timeout) begin
            retry_d = retry_q + RW'(1);
            state_d = ((32'(retry_q) + 32'd1) >= MAX_RETRY) ? S_FAIL : S_RESET1;
        end

        if (USER_RST) begin
            state_d  = S_RESET1;
            retry_d  = '0;
            relock_d = relock_q;
        end

        if (USER_RST || (state_d != state_q)) cnt_d = '0;
        else if (cnt_q == '1)                 cnt_d = cnt_q;
        else                                  cnt_d = cnt_q + CW'(1);
    end

    always_comb begin
        dcm1_rst_d = 1'b0;
        dcm2_rst_d = 1'b0;
        sys_rst_d  = 1'b1;
        ready_d    = 1'b0;
        error_d    = 1'b0;
        case (state_d)
            S_RESET1: begin dcm1_rst_d = 1'b1; dcm2_rst_d = 1'b1; end
            S_WAIT1:  dcm2_rst_d = 1'b1;
            S_RESET2: dcm2_rst_d = 1'b1;
            S_RUN: begin sys_rst_d = 1'b0; ready_d = 1'b1; end
            S_FAIL: begin
                dcm1_rst_d = 1'b1;
                dcm2_rst_d = 1'b1;
                error_d    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            meta_q     <= '0;
            sync_q     <= '0;
            state_q    <= S_RESET1;
            cnt_q      <= '0;
            retry_q    <= '0;
            relock_q   <= '0;
            dcm1_rst_q <= 1'b1;
            dcm2_rst_q <= 1'b1;
            sys_rst_q  <= 1'b1;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            meta_q     <= {STATUS2_CLKIN_STOP, STATUS1_CLKIN_STOP, LOCKED2, LOCKED1};
            sync_q     <= meta_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            relock_q   <= relock_d;
            dcm1_rst_q <= dcm1_rst_d;
            dcm2_rst_q <= dcm2_rst_d;
            sys_rst_q  <= sys_rst_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
        end
    end

    assign DCM1_RST   = dcm1_rst_q;
    assign DCM2_RST   = dcm2_rst_q;
    assign SYS_RST    = sys_rst_q;
    assign READY      = ready_q;
    assign ERROR      = error_q;
    assign RELOCK_CNT = relock_q;

endmodule

// File: tb/tb_dcm_lock_seq.sv
// Scoreboarded bench for dcm_lock_seq: a countdown-based phase model predicts the
// outputs after every clock edge; a negedge monitor compares them against the DUT.
module tb_dcm_lock_seq;
    localparam int RST_C = 3;
    localparam int TO_C  = 20;
    localparam int SET_C = 8;
    localparam int MR    = 2;

    localparam int P_RESET1 = 0;
    localparam int P_WAIT1  = 1;
    localparam int P_RESET2 = 2;
    localparam int P_WAIT2  = 3;
    localparam int P_SETTLE = 4;
    localparam int P_RUN    = 5;
    localparam int P_FAIL   = 6;

    logic       clk = 1'b0;
    logic       bus_rst, user_rst, locked1, locked2, status1, status2;
    logic       dcm1_rst, dcm2_rst, sys_rst, ready, error;
    logic [7:0] relock_cnt;

    dcm_lock_seq #(
        .RST_CYCLES   (RST_C),
        .LOCK_TIMEOUT (TO_C),
        .SETTLE_CYCLES(SET_C),
        .MAX_RETRY    (MR)
    ) dut (
        .BUS_CLK           (clk),
        .BUS_RST           (bus_rst),
        .USER_RST          (user_rst),
        .LOCKED1           (locked1),
        .LOCKED2           (locked2),
        .STATUS1_CLKIN_STOP(status1),
        .STATUS2_CLKIN_STOP(status2),
        .DCM1_RST          (dcm1_rst),
        .DCM2_RST          (dcm2_rst),
        .SYS_RST           (sys_rst),
        .READY             (ready),
        .ERROR             (error),
        .RELOCK_CNT        (relock_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    logic [12:0] exp_q[$];
    logic [12:0] mon_exp, mon_act;

    // {DCM1_RST, DCM2_RST, SYS_RST, READY, ERROR} for each phase
    logic [4:0] out_tab [7] = '{5'b11100, 5'b01100, 5'b01100, 5'b00100,
                                5'b00100, 5'b00010, 5'b11101};

    int       m_phase, m_left, m_retry, m_relock;
    bit [3:0] m_sa, m_sb;

    function automatic int phase_len(int p);
        case (p)
            P_RESET1, P_RESET2: return RST_C;
            P_WAIT1, P_WAIT2:   return TO_C;
            P_SETTLE:           return SET_C;
            default:            return 0;
        endcase
    endfunction

    // One clock edge of the reference: pins are those the DUT samples on this edge.
    function automatic void model_edge(bit brst, bit urst, bit [3:0] pins);
        bit l1, l2, s1, s2, to, bump;
        int np;
        if (brst) begin
            m_phase  = P_RESET1;
            m_left   = RST_C;
            m_retry  = 0;
            m_relock = 0;
            m_sa     = '0;
            m_sb     = '0;
            return;
        end
        {s2, s1, l2, l1} = m_sb;
        np   = m_phase;
        to   = 1'b0;
        bump = 1'b0;
        if (urst) begin
            np      = P_RESET1;
            m_retry = 0;
        end else begin
            case (m_phase)
                P_RESET1: if (m_left == 1) np = P_WAIT1;
                P_WAIT1: begin
                    if (l1 && !s1)       np = P_RESET2;
                    else if (m_left == 1) to = 1'b1;
                end
                P_RESET2: begin
                    if (!l1)             np = P_RESET1;
                    else if (m_left == 1) np = P_WAIT2;
                end
                P_WAIT2: begin
                    if (!l1)             np = P_RESET1;
                    else if (l2)         np = P_SETTLE;
                    else if (m_left == 1) to = 1'b1;
                end
                P_SETTLE: begin
                    if (!l1 || s1)       np = P_RESET1;
                    else if (!l2 || s2)  np = P_RESET2;
                    else if (m_left == 1) begin
                        np      = P_RUN;
                        m_retry = 0;
                    end
                end
                P_RUN: begin
                    if (!l1 || s1) begin
                        np = P_RESET1; bump = 1'b1;
                    end else if (!l2 || s2) begin
                        np = P_RESET2; bump = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (to) begin
            m_retry++;
            np = (m_retry >= MR) ? P_FAIL : P_RESET1;
        end
        if (bump && m_relock < 255) m_relock++;
        if (urst || np != m_phase) begin
            m_phase = np;
            m_left  = phase_len(np);
        end else if (m_left > 1) begin
            m_left--;
        end
        m_sb = m_sa;
        m_sa = pins;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
        model_edge(bus_rst, user_rst, {status2, status1, locked2, locked1});
        exp_q.push_back({out_tab[m_phase], 8'(m_relock)});
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cycle, got, want);
        end
    endtask

    task automatic wait_phase(input int p, input int budget);
        int n = 0;
        while (m_phase != p && n < budget) begin
            tick();
            n++;
        end
        if (m_phase != p) begin
            total++;
            bad++;
            $display("FAIL wait_phase cycle=%0d got=%0d want=%0d", cycle, m_phase, p);
        end
    endtask

    // Monitor: the DUT presents a new output word after every edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_act = {dcm1_rst, dcm2_rst, sys_rst, ready, error, relock_cnt};
                total++;
                if (mon_act !== mon_exp) begin
                    bad++;
                    $display("FAIL outputs cycle=%0d got dcm1=%b dcm2=%b sys=%b rdy=%b err=%b cnt=%0d want dcm1=%b dcm2=%b sys=%b rdy=%b err=%b cnt=%0d",
                             cycle, mon_act[12], mon_act[11], mon_act[10], mon_act[9], mon_act[8], mon_act[7:0],
                             mon_exp[12], mon_exp[11], mon_exp[10], mon_exp[9], mon_exp[8], mon_exp[7:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d got=running want=finished", cycle);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus_rst  = 1'b1;
        user_rst = 1'b0;
        locked1  = 1'b0;
        locked2  = 1'b0;
        status1  = 1'b0;
        status2  = 1'b0;
        repeat (3) tick();
        check("reset_sys", 32'(sys_rst), 1);
        check("reset_err", 32'(error), 0);
        bus_rst = 1'b0;

        // Clean bring-up
        wait_phase(P_WAIT1, 20);
        repeat (5) tick();
        locked1 = 1'b1;
        wait_phase(P_WAIT2, 40);
        repeat (5) tick();
        locked2 = 1'b1;
        wait_phase(P_RUN, 60);
        check("bringup_ready", 32'(ready), 1);
        check("bringup_relock", 32'(relock_cnt), 0);

        // Single-cycle LOCKED2 loss in RUN
        locked2 = 1'b0;
        tick();
        locked2 = 1'b1;
        wait_phase(P_RESET2, 10);
        check("loss2_dcm1", 32'(dcm1_rst), 0);
        wait_phase(P_RUN, 60);
        check("loss2_relock", 32'(relock_cnt), 1);

        // LOCKED1 glitch during SETTLE
        locked2 = 1'b0;
        tick();
        locked2 = 1'b1;
        wait_phase(P_SETTLE, 40);
        repeat (3) tick();
        locked1 = 1'b0;
        tick();
        locked1 = 1'b1;
        wait_phase(P_RESET1, 10);
        check("glitch_sys", 32'(sys_rst), 1);
        wait_phase(P_RUN, 80);
        check("glitch_relock", 32'(relock_cnt), 2);

        // Locks never return: retries exhausted
        locked1 = 1'b0;
        locked2 = 1'b0;
        wait_phase(P_FAIL, 200);
        repeat (5) tick();
        check("fail_err", 32'(error), 1);
        check("fail_resets", 32'({dcm1_rst, dcm2_rst, sys_rst}), 7);
        user_rst = 1'b1;
        tick();
        user_rst = 1'b0;
        check("user_err", 32'(error), 0);
        check("user_dcm1", 32'(dcm1_rst), 1);
        check("user_relock", 32'(relock_cnt), 3);

        // Lock reaches the FSM on the timeout cycle
        n = 0;
        while (!(m_phase == P_WAIT1 && m_left == 3) && n < 100) begin
            tick();
            n++;
        end
        check("simA_reach", 32'(m_phase == P_WAIT1 && m_left == 3), 1);
        locked1 = 1'b1;
        repeat (3) tick();
        check("simA_dcm1", 32'(dcm1_rst), 0);
        check("simA_err", 32'(error), 0);
        locked2 = 1'b1;
        wait_phase(P_RUN, 60);

        // USER_RST and a lock loss reach the FSM together
        locked1 = 1'b0;
        tick();
        tick();
        user_rst = 1'b1;
        tick();
        user_rst = 1'b0;
        locked1  = 1'b1;
        check("simB_dcm1", 32'(dcm1_rst), 1);
        check("simB_relock", 32'(relock_cnt), 3);
        wait_phase(P_RUN, 80);

        // Relock counter saturation
        for (int i = 0; i < 260; i++) begin
            locked2 = 1'b0;
            tick();
            locked2 = 1'b1;
            wait_phase(P_RESET2, 10);
            wait_phase(P_RUN, 60);
        end
        check("sat_relock", 32'(relock_cnt), 255);
        bus_rst = 1'b1;
        tick();
        bus_rst = 1'b0;
        check("sat_clear", 32'(relock_cnt), 0);

        // Randomised lock / clock-stop / restart traffic
        for (int i = 0; i < 3000; i++) begin
            if (locked1) begin
                if ($urandom_range(0, 59) == 0) locked1 = 1'b0;
            end else if ($urandom_range(0, 7) == 0) locked1 = 1'b1;
            if (locked2) begin
                if ($urandom_range(0, 59) == 0) locked2 = 1'b0;
            end else if ($urandom_range(0, 7) == 0) locked2 = 1'b1;
            status1  = status1 ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 299) == 0);
            status2  = status2 ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 299) == 0);
            user_rst = ($urandom_range(0, 249) == 0);
            tick();
        end
        user_rst = 1'b0;
        tick();
        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
